// File: rtl/key_conditioner_pkg.sv
// Shared types and constants for the pushbutton conditioner.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: per-channel FSM state enum, default cycle counts for a 50 MHz
// clock, and the helpers used to size the saturating counters.
package key_conditioner_pkg;

  typedef enum logic [1:0] {
    UP           = 2'd0,
    PRESS_WAIT   = 2'd1,
    DOWN         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_e;

  // Defaults assume a 50 MHz clock.
  localparam int DEF_NKEYS                = 4;
  localparam int DEF_DEBOUNCE_CYCLES      = 500000;    // 10 ms
  localparam int DEF_REPEAT_DELAY_CYCLES  = 25000000;  // 0.5 s
  localparam int DEF_REPEAT_PERIOD_CYCLES = 5000000;   // 0.1 s

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Every counter only needs to reach (cycles - 1), so $clog2(cycles) bits
  // are enough; never allow a zero-width counter.
  function automatic int cnt_width(input int max_cycles);
    int w;
    w = $clog2(max_cycles);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int DEF_CNT_W = cnt_width(max3(DEF_DEBOUNCE_CYCLES,
                                            DEF_REPEAT_DELAY_CYCLES,
                                            DEF_REPEAT_PERIOD_CYCLES));

endpackage

// File: rtl/key_debounce_ch.sv
// One pushbutton channel: 2-flop synchronizer, debounce FSM, optional auto-repeat.
// Latency: press pulse / held edge appear DEBOUNCE_CYCLES+2 clocks after a clean key_n edge.
// Backpressure: none; pressed is a fire-and-forget single-cycle pulse.
// Ports: clk, reset_n (async active-low), key_n (raw, 0 = pressed, async),
//        pressed (registered 1-cycle pulse), held (registered debounced level).
// Optional: define KEY_AUTOREPEAT_EN to emit repeat pulses while the key stays down.
module key_debounce_ch
  import key_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic pressed,
  output logic held
);

  localparam int CNT_W = cnt_width(max3(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES,
                                        REPEAT_PERIOD_CYCLES));
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Saturating increment: counters must hold at all-ones rather than wrap.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_ONE;
  endfunction

  logic             sync1_q, sync1_d;
  logic             sync_n_q, sync_n_d;
  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pressed_q, pressed_d;
  logic             held_q, held_d;

`ifdef KEY_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD_CYCLES - 1);
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic             rphase_q, rphase_d;  // 0: waiting initial delay, 1: periodic
`endif

  always_comb begin
    sync1_d   = key_n;
    sync_n_d  = sync1_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    pressed_d = 1'b0;
    held_d    = held_q;

    case (state_q)
      UP: begin
        if (!sync_n_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (sync_n_q) begin
          state_d = UP;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d   = DOWN;
          pressed_d = 1'b1;
          held_d    = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      DOWN: begin
        if (sync_n_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        // A bounce back to low returns to DOWN silently: no second pulse.
        if (!sync_n_q) begin
          state_d = DOWN;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = UP;
          held_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: begin
        state_d = UP;
        cnt_d   = '0;
        held_d  = 1'b0;
      end
    endcase

`ifdef KEY_AUTOREPEAT_EN
    rcnt_d   = rcnt_q;
    rphase_d = rphase_q;
    // Repeat timing only advances while the channel remains in DOWN; any
    // other cycle (including the RELEASE_WAIT->DOWN re-entry) restarts the delay.
    if (state_q == DOWN && !sync_n_q) begin
      if ((!rphase_q && rcnt_q == RD_LAST) || (rphase_q && rcnt_q == RP_LAST)) begin
        pressed_d = 1'b1;
        rcnt_d    = '0;
        rphase_d  = 1'b1;
      end else begin
        rcnt_d = sat_inc(rcnt_q);
      end
    end else begin
      rcnt_d   = '0;
      rphase_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= 1'b1;
      sync_n_q  <= 1'b1;
      state_q   <= UP;
      cnt_q     <= '0;
      pressed_q <= 1'b0;
      held_q    <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      rcnt_q    <= '0;
      rphase_q  <= 1'b0;
`endif
    end else begin
      sync1_q   <= sync1_d;
      sync_n_q  <= sync_n_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
      held_q    <= held_d;
`ifdef KEY_AUTOREPEAT_EN
      rcnt_q    <= rcnt_d;
      rphase_q  <= rphase_d;
`endif
    end
  end

  assign pressed = pressed_q;
  assign held    = held_q;

endmodule

// File: rtl/key_conditioner.sv
// Conditions NKEYS raw active-low pushbuttons into press pulses and debounced levels.
// Latency: DEBOUNCE_CYCLES+2 clocks from a clean key_n edge to pressed/held.
// Backpressure: none; channels are independent and never masked.
// Ports: clk, reset_n (async active-low), key_n[NKEYS] (raw, 0 = pressed),
//        pressed[NKEYS] (1-cycle pulses), held[NKEYS] (1 = key down).
// Optional: KEY_AUTOREPEAT_EN enables auto-repeat pulses in each channel.
module key_conditioner
  import key_conditioner_pkg::*;
#(
  parameter int NKEYS                = DEF_NKEYS,
  parameter int DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NKEYS-1:0] key_n,
  output logic [NKEYS-1:0] pressed,
  output logic [NKEYS-1:0] held
);

  for (genvar g = 0; g < NKEYS; g++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
      .REPEAT_PERIOD_CYCLES(REPEAT_PERIOD_CYCLES)
    ) u_ch (
      .clk    (clk),
      .reset_n(reset_n),
      .key_n  (key_n[g]),
      .pressed(pressed[g]),
      .held   (held[g])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed scenarios plus randomized key activity,
// every cycle compared against a behavioural model of the debounce rules.
module tb_key_conditioner;

  localparam int NK = 4;
  localparam int DB = 8;
  localparam int RD = 40;
  localparam int RP = 10;
`ifdef KEY_AUTOREPEAT_EN
  localparam bit AUTOREP = 1'b1;
`else
  localparam bit AUTOREP = 1'b0;
`endif

  logic          clk;
  logic          reset_n;
  logic [NK-1:0] key_n;
  logic [NK-1:0] pressed;
  logic [NK-1:0] held;

  int n_checks = 0;
  int n_fail   = 0;

  key_conditioner #(
    .NKEYS(NK), .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY_CYCLES(RD), .REPEAT_PERIOD_CYCLES(RP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .key_n(key_n), .pressed(pressed), .held(held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a key level flips after DB consecutive synchronized
  // samples that disagree with it; the synchronizer is a 2-sample delay.
  bit            m_s1 [NK];
  bit            m_s2 [NK];
  bit            m_lvl[NK];
  int            m_run [NK];
  int            m_hold[NK];   // clock edges spent stably down since press/re-entry
  logic [NK-1:0] exp_pressed;
  logic [NK-1:0] exp_held;

  task automatic model_reset();
    for (int k = 0; k < NK; k++) begin
      m_s1[k] = 1'b1; m_s2[k] = 1'b1; m_lvl[k] = 1'b0;
      m_run[k] = 0; m_hold[k] = 0;
    end
    exp_pressed = '0;
    exp_held    = '0;
  endtask

  task automatic model_edge();
    for (int k = 0; k < NK; k++) begin
      bit dn;
      dn = ~m_s2[k];
      exp_pressed[k] = 1'b0;
      if (dn != m_lvl[k]) begin
        m_hold[k] = 0;
        if (m_run[k] + 1 == DB) begin
          m_lvl[k] = dn;
          m_run[k] = 0;
          exp_pressed[k] = dn;
        end else begin
          m_run[k]++;
        end
      end else begin
        if (m_lvl[k] && m_run[k] == 0) begin
          m_hold[k]++;
          if (AUTOREP && (m_hold[k] == RD ||
                          (m_hold[k] > RD && (m_hold[k] - RD) % RP == 0)))
            exp_pressed[k] = 1'b1;
        end else begin
          m_hold[k] = 0;
        end
        m_run[k] = 0;
      end
      exp_held[k] = m_lvl[k];
      m_s2[k] = m_s1[k];
      m_s1[k] = key_n[k];
    end
  endtask

  // One clock: model advances on the rising edge, outputs checked on the falling edge.
  task automatic step();
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_edge();
    @(negedge clk);
    check_eq("pressed", 32'(pressed), 32'(exp_pressed));
    check_eq("held", 32'(held), 32'(exp_held));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Steps until pressed[k] (sel=0) or held[k] (sel=1) equals val; n=-1 on timeout.
  task automatic wait_bit(input int k, input bit sel, input bit val, input int max_steps,
                          output int n);
    n = -1;
    for (int i = 1; i <= max_steps; i++) begin
      step();
      if (((sel ? held[k] : pressed[k]) == val) && n < 0) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int cnt;
    int dur[NK];

    reset_n = 1'b0;
    key_n   = '1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_pressed", 32'(pressed), 32'h0);
    check_eq("rst_held", 32'(held), 32'h0);
    reset_n = 1'b1;
    steps(5);

    // 1/6: clean press held for 100 cycles, then release.
    key_n[0] = 1'b0;
    wait_bit(0, 1'b0, 1'b1, 30, n);
    check_eq("t1_press_latency", 32'(n), 32'd10);
    check_eq("t1_held_with_pulse", 32'(held[0]), 32'd1);
    cnt = 1;
    for (int i = n + 1; i <= 100; i++) begin
      step();
      if (pressed[0]) cnt++;
    end
    check_eq("t1_pulse_count", 32'(cnt), AUTOREP ? 32'd7 : 32'd1);
    key_n[0] = 1'b1;
    wait_bit(0, 1'b1, 1'b0, 30, n);
    check_eq("t1_release_latency", 32'(n), 32'd10);
    steps(10);

    // 2: bounce at 3-cycle spacing, then stay low.
    cnt = 0;
    for (int b = 0; b < 4; b++) begin
      key_n[1] = b[0];
      for (int i = 0; i < 3; i++) begin
        step();
        if (pressed[1]) cnt++;
      end
    end
    key_n[1] = 1'b0;
    check_eq("t2_bounce_pulses", 32'(cnt), 32'd0);
    wait_bit(1, 1'b0, 1'b1, 30, n);
    check_eq("t2_press_latency", 32'(n), 32'd10);
    key_n[1] = 1'b1;
    steps(20);

    // 3: all keys at once.
    key_n = '0;
    n = -1;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (pressed != '0) begin n = i; break; end
    end
    check_eq("t3_latency", 32'(n), 32'd10);
    check_eq("t3_all_pulse", 32'(pressed), 32'hF);
    step();
    check_eq("t3_single_cycle", 32'(pressed), 32'h0);
    key_n = '1;
    steps(20);

    // 4: reset mid-PRESS_WAIT while key 0 is already debounced down.
    key_n[0] = 1'b0;
    steps(12);
    key_n[2] = 1'b0;
    steps(5);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_eq("t4_async_pressed", 32'(pressed), 32'h0);
    check_eq("t4_async_held", 32'(held), 32'h0);
    step();
    reset_n = 1'b1;
    wait_bit(2, 1'b0, 1'b1, 30, n);
    check_eq("t4_post_reset_latency", 32'(n), 32'd10);

    // 5: short release glitch while DOWN.
    key_n[0] = 1'b1;
    steps(4);
    key_n[0] = 1'b0;
    cnt = 0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (pressed[0]) cnt++;
      if (!held[0]) n++;
    end
    check_eq("t5_glitch_pulses", 32'(cnt), 32'd0);
    check_eq("t5_held_drops", 32'(n), 32'd0);
    key_n = '1;
    steps(20);

    // Randomized activity: mixes bounces, clean presses, long holds, rare resets.
    for (int k = 0; k < NK; k++) dur[k] = 1;
    for (int i = 0; i < 2500; i++) begin
      for (int k = 0; k < NK; k++) begin
        dur[k]--;
        if (dur[k] <= 0) begin
          key_n[k] = ~key_n[k];
          dur[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 130))
                                               : int'($urandom_range(1, 12));
        end
      end
      if ($urandom_range(0, 499) == 0) begin
        reset_n = 1'b0;
        #1;
        model_reset();
        check_eq("rand_async_rst", 32'({pressed, held}), 32'h0);
        step();
        reset_n = 1'b1;
      end else begin
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
